// File: rtl/seq_det_pkg.sv
// Shared types and sizing helpers for the serial pattern detector.
package seq_det_pkg;

    typedef enum logic [1:0] {
        S_FILL = 2'd0,
        S_SCAN = 2'd1,
        S_HIT  = 2'd2
    } seq_det_state_t;

    // Width of a counter that must hold 0..pat_w inclusive.
    function automatic int fill_width(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; clr restarts from zero, sat flags the all-ones value.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         sat
);

    assign sat = &count;

    always_ff @(posedge clk) begin
        if (reset || clr)
            count <= '0;
        else if (inc && !sat)
            count <= count + 1'b1;
    end

endmodule

// File: rtl/seq_det_moore.sv
// Moore serial pattern detector: compares the last PAT_W accepted bits against
// a run-time pattern, pulses d_out for one cycle per hit and counts hits.
module seq_det_moore
    import seq_det_pkg::*;
#(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             en,
    input  logic             d_in,
    input  logic [PAT_W-1:0] pattern,
    input  logic             overlap,
    output logic             d_out,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat
);

    localparam int FILL_W = fill_width(PAT_W);
    localparam logic [FILL_W-1:0] FULL = FILL_W'(PAT_W);

    logic [PAT_W-1:0]  hist, hist_nxt;
    logic [FILL_W-1:0] fill, fill_nxt;
    logic              hit;
    seq_det_state_t    state;

    always_comb begin
        hist_nxt = {hist[PAT_W-2:0], d_in};
        fill_nxt = (fill == FULL) ? fill : fill + 1'b1;
        hit      = (fill_nxt == FULL) && (hist_nxt == pattern);
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            hist  <= '0;
            fill  <= '0;
            state <= S_FILL;
        end else if (en) begin
            if (hit) begin
                state <= S_HIT;
                // Non-overlapping mode consumes the matched bits immediately.
                hist  <= overlap ? hist_nxt : '0;
                fill  <= overlap ? fill_nxt : '0;
            end else begin
                hist  <= hist_nxt;
                fill  <= fill_nxt;
                state <= (fill_nxt == FULL) ? S_SCAN : S_FILL;
            end
        end else if (state == S_HIT) begin
            // fill already reflects the mode the hit was taken in.
            state <= (fill == FULL) ? S_SCAN : S_FILL;
        end
    end

    assign d_out = (state == S_HIT);

    sat_counter #(.W(CNT_W)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (clear),
        .inc   (en && hit),
        .count (match_cnt),
        .sat   (cnt_sat)
    );

endmodule

// File: tb/tb_seq_det_moore.sv
// Directed bench for seq_det_moore; a 2-bit-counter copy shares the stimulus.
module tb_seq_det_moore;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       clear = 1'b0;
    logic       en = 1'b0;
    logic       d_in = 1'b0;
    logic [3:0] pattern = 4'b1011;
    logic       overlap = 1'b0;
    logic       d_out, cnt_sat, d_out_s, sat_s;
    logic [7:0] match_cnt;
    logic [1:0] cnt_s;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seq_det_moore #(.PAT_W(4), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .clear(clear), .en(en), .d_in(d_in),
        .pattern(pattern), .overlap(overlap),
        .d_out(d_out), .match_cnt(match_cnt), .cnt_sat(cnt_sat)
    );

    seq_det_moore #(.PAT_W(4), .CNT_W(2)) dut_s (
        .clk(clk), .reset(reset), .clear(clear), .en(en), .d_in(d_in),
        .pattern(pattern), .overlap(overlap),
        .d_out(d_out_s), .match_cnt(cnt_s), .cnt_sat(sat_s)
    );

    task automatic step(input logic e, input logic d);
        en = e;
        d_in = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1'b0, 1'b0);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (d_out !== 1'b0) begin n_err++; $display("FAIL reset_d_out got %b exp 0", d_out); end
        n_cmp++; if (match_cnt !== 8'd0) begin n_err++; $display("FAIL reset_cnt got %0d exp 0", match_cnt); end
        n_cmp++; if (cnt_sat !== 1'b0) begin n_err++; $display("FAIL reset_sat got %b exp 0", cnt_sat); end
        n_cmp++; if (dut.fill !== 3'd0) begin n_err++; $display("FAIL reset_fill got %0d exp 0", dut.fill); end
    endtask

    task automatic test_pattern_1011();
        logic [6:0] bits;
        logic       exp;
        bits = 7'b1011011;
        for (int ov = 0; ov < 2; ov++) begin
            do_reset();
            pattern = 4'b1011;
            overlap = (ov == 1);
            for (int i = 0; i < 7; i++) begin
                step(1'b1, bits[6-i]);
                exp = (i == 3) || (ov == 1 && i == 6);
                n_cmp++;
                if (d_out !== exp) begin
                    n_err++; $display("FAIL p1011_ov%0d_bit%0d d_out got %b exp %b", ov, i + 1, d_out, exp);
                end
            end
            n_cmp++;
            if (match_cnt !== ((ov == 1) ? 8'd2 : 8'd1)) begin
                n_err++; $display("FAIL p1011_ov%0d_cnt got %0d exp %0d", ov, match_cnt, (ov == 1) ? 2 : 1);
            end
            step(1'b0, 1'b0);
            n_cmp++; if (d_out !== 1'b0) begin n_err++; $display("FAIL p1011_ov%0d_tail got %b exp 0", ov, d_out); end
        end
    endtask

    task automatic test_back_to_back();
        logic exp;
        for (int ov = 0; ov < 2; ov++) begin
            do_reset();
            pattern = 4'b1111;
            overlap = (ov == 1);
            for (int i = 0; i < 8; i++) begin
                step(1'b1, 1'b1);
                exp = (ov == 1) ? (i >= 3) : (i == 3 || i == 7);
                n_cmp++;
                if (d_out !== exp) begin
                    n_err++; $display("FAIL ones_ov%0d_bit%0d d_out got %b exp %b", ov, i + 1, d_out, exp);
                end
            end
            n_cmp++;
            if (match_cnt !== ((ov == 1) ? 8'd5 : 8'd2)) begin
                n_err++; $display("FAIL ones_ov%0d_cnt got %0d exp %0d", ov, match_cnt, (ov == 1) ? 5 : 2);
            end
        end
    endtask

    task automatic test_en_gaps();
        logic [3:0] bits;
        bits = 4'b1011;
        do_reset();
        pattern = 4'b1011;
        overlap = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, bits[3-i]);
            n_cmp++;
            if (d_out !== (i == 3)) begin n_err++; $display("FAIL gap_bit%0d d_out got %b exp %b", i + 1, d_out, (i == 3)); end
            for (int k = 0; k < 2; k++) begin
                step(1'b0, ~bits[3-i]);
                n_cmp++;
                if (d_out !== 1'b0) begin n_err++; $display("FAIL gap_idle%0d_%0d d_out got %b exp 0", i + 1, k, d_out); end
                n_cmp++;
                if (dut.fill !== 3'(i + 1)) begin n_err++; $display("FAIL gap_fill%0d_%0d got %0d exp %0d", i + 1, k, dut.fill, i + 1); end
            end
        end
        n_cmp++; if (match_cnt !== 8'd1) begin n_err++; $display("FAIL gap_cnt got %0d exp 1", match_cnt); end
    endtask

    task automatic test_saturation();
        logic [1:0] exp_cnt;
        do_reset();
        pattern = 4'b1111;
        overlap = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b1);
            exp_cnt = (i < 3) ? 2'd0 : (i >= 5) ? 2'd3 : 2'(i - 2);
            n_cmp++;
            if (d_out_s !== (i >= 3)) begin n_err++; $display("FAIL sat_bit%0d d_out got %b exp %b", i + 1, d_out_s, (i >= 3)); end
            n_cmp++;
            if (cnt_s !== exp_cnt) begin n_err++; $display("FAIL sat_bit%0d cnt got %0d exp %0d", i + 1, cnt_s, exp_cnt); end
            n_cmp++;
            if (sat_s !== (i >= 5)) begin n_err++; $display("FAIL sat_bit%0d flag got %b exp %b", i + 1, sat_s, (i >= 5)); end
        end
    endtask

    task automatic test_clear();
        logic [2:0] pre;
        logic [3:0] post;
        pre = 3'b101;
        post = 4'b1011;
        do_reset();
        pattern = 4'b1011;
        overlap = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b1, pre[2-i]);
        clear = 1'b1;
        step(1'b1, 1'b1);
        clear = 1'b0;
        n_cmp++; if (d_out !== 1'b0) begin n_err++; $display("FAIL clr_d_out got %b exp 0", d_out); end
        n_cmp++; if (dut.fill !== 3'd0) begin n_err++; $display("FAIL clr_fill0 got %0d exp 0", dut.fill); end
        for (int i = 0; i < 4; i++) begin
            step(1'b1, post[3-i]);
            n_cmp++;
            if (d_out !== (i == 3)) begin n_err++; $display("FAIL clr_bit%0d d_out got %b exp %b", i + 1, d_out, (i == 3)); end
            if (i == 0) begin
                n_cmp++;
                if (dut.fill !== 3'd1) begin n_err++; $display("FAIL clr_fill1 got %0d exp 1", dut.fill); end
            end
        end
        n_cmp++; if (match_cnt !== 8'd1) begin n_err++; $display("FAIL clr_cnt got %0d exp 1", match_cnt); end
    endtask

    task automatic test_restart_in_hit();
        logic [3:0] bits;
        bits = 4'b1011;
        for (int r = 0; r < 2; r++) begin
            do_reset();
            pattern = 4'b1011;
            overlap = 1'b1;
            for (int i = 0; i < 4; i++) step(1'b1, bits[3-i]);
            n_cmp++; if (d_out !== 1'b1) begin n_err++; $display("FAIL hit%0d_pre d_out got %b exp 1", r, d_out); end
            if (r == 0) reset = 1'b1; else clear = 1'b1;
            step(1'b1, 1'b1);
            reset = 1'b0;
            clear = 1'b0;
            n_cmp++; if (d_out !== 1'b0) begin n_err++; $display("FAIL hit%0d_post d_out got %b exp 0", r, d_out); end
            n_cmp++; if (match_cnt !== 8'd0) begin n_err++; $display("FAIL hit%0d_post cnt got %0d exp 0", r, match_cnt); end
        end
    endtask

    initial begin
        test_reset();
        test_pattern_1011();
        test_back_to_back();
        test_en_gaps();
        test_saturation();
        test_clear();
        test_restart_in_hit();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
